seq_chunk_adder: RTL and testbench



---
 rtl/seq_adder_pkg.sv | 15 +
 rtl/seq_chunk_adder_rca.sv | 25 ++
 rtl/seq_chunk_adder.sv | 156 +++++++++++++++
 tb/tb_seq_chunk_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types for the sequential chunked adder.
// State encoding and counter-width helper.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca.sv
// Combinational CHUNK-bit ripple-carry slice.
// Chain of full adders, carry rippling LSB to MSB.
module chunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i])
                    | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per cycle through one slice.
// Define SEQ_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] sl_sum;
  logic             sl_co;
  logic [WIDTH-1:0] res_nxt;

  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .a_i    (a_sh_q[CHUNK-1:0]),
    .b_i    (b_sh_q[CHUNK-1:0]),
    .cin_i  (carry_q),
    .sum_o  (sl_sum),
    .cout_o (sl_co)
  );

  // New slice result enters at the top; after NCHUNK steps it is aligned.
  assign res_nxt = (res_sh_q >> CHUNK)
                 | (WIDTH'(sl_sum) << (WIDTH - CHUNK));

`ifdef SEQ_ADDER_OVF_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    in_ready = 1'b0;
`ifdef SEQ_ADDER_OVF_EN
    sa_d     = sa_q;
    sb_d     = sb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_BUSY: begin
        a_sh_d   = a_sh_q >> CHUNK;
        b_sh_d   = b_sh_q >> CHUNK;
        res_sh_d = res_nxt;
        carry_d  = sl_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_nxt;
          cout_d  = sl_co;
          state_d = ST_DONE;
`ifdef SEQ_ADDER_OVF_EN
          ovf_d   = (sa_q == sb_q)
                  && (sl_sum[CHUNK-1] != sa_q);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      // Unused encoding behaves as IDLE.
      default: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef SEQ_ADDER_OVF_EN
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: vector table, corner sequences,
// random ops vs arithmetic model, exhaustive 4-bit sweep.
module tb_seq_chunk_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
  logic       ovf_w;

  logic       e_valid = 1'b0;
  logic [3:0] e_a = '0;
  logic [3:0] e_b = '0;
  logic       e_cin = 1'b0;
  logic       e_ready [3];
  logic       e_ov [3];
  logic [3:0] e_sum [3];
  logic       e_cout [3];
  logic       e_ovf [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(ovf_w)
`endif
  );
`ifndef SEQ_ADDER_OVF_EN
  assign ovf_w = 1'b0;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_ex
    seq_chunk_adder #(.WIDTH(4), .CHUNK(1 << g)) u (
      .clk(clk), .rst(rst),
      .in_valid(e_valid), .in_ready(e_ready[g]),
      .a(e_a), .b(e_b), .cin(e_cin),
      .out_valid(e_ov[g]), .out_ready(1'b1),
      .sum(e_sum[g]), .cout(e_cout[g])
`ifdef SEQ_ADDER_OVF_EN
      , .ovf(e_ovf[g])
`endif
    );
`ifndef SEQ_ADDER_OVF_EN
    assign e_ovf[g] = 1'b0;
`endif
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Accept one op, then wait for out_valid; lat counts edges after accept.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, output int lat,
                       output logic [7:0] s, output logic co,
                       output logic ov);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    a = ia;
    b = ib;
    cin = ic;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    s = sum;
    co = cout;
    ov = ovf_w;
  endtask

  function automatic logic ref_ovf(input logic [7:0] x,
                                   input logic [7:0] y,
                                   input logic c);
    int r;
    r = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (r > 127) || (r < -128);
  endfunction

  vec_t       tbl [6];
  int         lat;
  logic [7:0] rs;
  logic       rc;
  logic       rv;
  logic [8:0] full;
  logic [7:0] ra, rb;
  logic       rcin;
  int         elat [3];
  logic [3:0] es [3];
  logic       ec [3];
  logic [4:0] eexp;
  logic [8:0] vv;
  int         seen;

  initial begin
    tbl[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_sum", int'(sum), 0);
    chk("reset_cout", int'(cout), 0);

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, lat, rs, rc, rv);
      chk("tbl_latency", lat, 2);
      chk("tbl_sum", int'(rs), int'(tbl[i].s));
      chk("tbl_cout", int'(rc), int'(tbl[i].co));
`ifdef SEQ_ADDER_OVF_EN
      chk("tbl_ovf", int'(rv), int'(tbl[i].ov));
`endif
      @(posedge clk);
      #1;
      chk("tbl_pulse_end", int'(out_valid), 0);
      chk("tbl_idle_ready", int'(in_ready), 1);
    end

    // Backpressure in DONE while new operands are offered.
    out_ready = 1'b0;
    do_op(8'h55, 8'h22, 1'b1, lat, rs, rc, rv);
    chk("hold_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'h11;
      b = 8'h00;
      cin = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(sum), 8'h78);
      chk("hold_cout", int'(cout), 0);
      chk("hold_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_valid", int'(out_valid), 0);
    chk("hold_release_ready", int'(in_ready), 1);
    chk("hold_sum_kept", int'(sum), 8'h78);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("hold_accept_busy", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("hold_next_latency", lat, 2);
    chk("hold_next_sum", int'(sum), 8'h11);
    @(posedge clk);

    // Reset one cycle into BUSY aborts the op.
    @(negedge clk);
    a = 8'h9A;
    b = 8'h33;
    cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_sum", int'(sum), 0);
    chk("abort_cout", int'(cout), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", int'(in_ready), 1);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rcin = 1'($urandom);
      out_ready = 1'b1;
      do_op(ra, rb, rcin, lat, rs, rc, rv);
      full = 9'(ra) + 9'(rb) + 9'(rcin);
      chk("rnd_latency", lat, 2);
      chk("rnd_result", int'({rc, rs}), int'(full));
`ifdef SEQ_ADDER_OVF_EN
      chk("rnd_ovf", int'(rv), int'(ref_ovf(ra, rb, rcin)));
`endif
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    for (int v = 0; v < 512; v++) begin
      vv = 9'(v);
      @(negedge clk);
      e_a = vv[3:0];
      e_b = vv[7:4];
      e_cin = vv[8];
      e_valid = 1'b1;
      @(posedge clk);
      #1 e_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        elat[d] = -1;
        es[d] = '0;
        ec[d] = 1'b0;
      end
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
          if (e_ov[d] && elat[d] < 0) begin
            elat[d] = k;
            es[d] = e_sum[d];
            ec[d] = e_cout[d];
          end
        end
      end
      eexp = 5'(vv[3:0]) + 5'(vv[7:4]) + 5'(vv[8]);
      for (int d = 0; d < 3; d++) begin
        chk("exh_latency", elat[d], 4 >> d);
        chk("exh_result", int'({ec[d], es[d]}), int'(eexp));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
